// File: rtl/autorange_controller_if.sv
// Bus between the autorange controller and its surroundings: counter results in,
// window period and accepted measurements out.
interface autorange_controller_if #(
  parameter int BITS = 12
);
  logic            result_valid;
  logic [6:0]      result_count;
  logic            manual_en;
  logic [1:0]      manual_range;
  logic [BITS-1:0] period;
  logic            period_load;
  logic [1:0]      range;
  logic            meas_valid;
  logic [6:0]      meas_count;
  logic [1:0]      meas_range;
  logic            over_range;
  logic            under_range;
  logic [2:0]      dbg_state;

  modport master (
    input  result_valid, result_count, manual_en, manual_range,
    output period, period_load, range, meas_valid, meas_count, meas_range,
           over_range, under_range, dbg_state
  );

  modport slave (
    output result_valid, result_count, manual_en, manual_range,
    input  period, period_load, range, meas_valid, meas_count, meas_range,
           over_range, under_range, dbg_state
  );
endinterface

// File: rtl/autorange_controller.sv
// Autoranging gate-window sequencer for the frequency counter: picks one of three
// decade windows with hysteresis and tags each accepted count with its range.
//
// state   | meaning
// INIT    | one cycle after reset, then load the current range's period
// LOAD    | period_load strobe visible, hold counter cleared
// SETTLE  | first result after a reload straddles the change; drop it
// MEASURE | wait for a result and capture its count
// EVAL    | publish the result, decide the next range
module autorange_controller #(
  parameter int BITS      = 12,
  parameter int PERIOD0   = 1199,
  parameter int PERIOD1   = 119,
  parameter int PERIOD2   = 11,
  parameter int HI_THRESH = 95,
  parameter int LO_THRESH = 9,
  parameter int HOLD_N    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  autorange_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_EVAL    = 3'd4
  } state_t;

  localparam logic [6:0] HI_T = 7'(HI_THRESH);
  localparam logic [6:0] LO_T = 7'(LO_THRESH);
  localparam logic [2:0] HOLD = 3'(HOLD_N);

  state_t          state;
  logic [1:0]      range_q;
  logic [BITS-1:0] period_q;
  logic            period_load_q;
  logic            meas_valid_q;
  logic [6:0]      meas_count_q;
  logic [1:0]      meas_range_q;
  logic            over_q;
  logic            under_q;
  logic [6:0]      cap_q;
  logic [2:0]      hold_q;
  logic            hold_dn_q;

  logic            is_hi;
  logic            is_lo;
  logic [1:0]      target;
  logic [2:0]      hold_base;
  logic [2:0]      hold_nxt;
  logic            dn_nxt;

  function automatic logic [BITS-1:0] period_of(input logic [1:0] r);
    case (r)
      2'd0:    period_of = BITS'(PERIOD0);
      2'd1:    period_of = BITS'(PERIOD1);
      default: period_of = BITS'(PERIOD2);
    endcase
  endfunction

  // Hold counts consecutive same-direction out-of-band results; a reversal restarts it at 1.
  always_comb begin
    is_hi     = (cap_q >= HI_T);
    is_lo     = (cap_q <= LO_T);
    target    = range_q;
    hold_base = 3'd0;
    hold_nxt  = 3'd0;
    dn_nxt    = hold_dn_q;
    if (bus.manual_en) begin
      target = (bus.manual_range == 2'd3) ? 2'd2 : bus.manual_range;
    end else if (is_hi && range_q != 2'd2) begin
      hold_base = (hold_q != 3'd0 && hold_dn_q) ? 3'd0 : hold_q;
      hold_nxt  = (hold_base >= HOLD) ? HOLD : hold_base + 3'd1;
      dn_nxt    = 1'b0;
      if (hold_nxt == HOLD) target = range_q + 2'd1;
    end else if (is_lo && range_q != 2'd0) begin
      hold_base = (hold_q != 3'd0 && !hold_dn_q) ? 3'd0 : hold_q;
      hold_nxt  = (hold_base >= HOLD) ? HOLD : hold_base + 3'd1;
      dn_nxt    = 1'b1;
      if (hold_nxt == HOLD) target = range_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_INIT;
      range_q       <= 2'd0;
      period_q      <= BITS'(PERIOD0);
      period_load_q <= 1'b0;
      meas_valid_q  <= 1'b0;
      meas_count_q  <= 7'd0;
      meas_range_q  <= 2'd0;
      over_q        <= 1'b0;
      under_q       <= 1'b0;
      cap_q         <= 7'd0;
      hold_q        <= 3'd0;
      hold_dn_q     <= 1'b0;
    end else begin
      period_load_q <= 1'b0;
      meas_valid_q  <= 1'b0;
      case (state)
        S_INIT: begin
          period_q      <= period_of(range_q);
          period_load_q <= 1'b1;
          state         <= S_LOAD;
        end
        S_LOAD: begin
          hold_q    <= 3'd0;
          hold_dn_q <= 1'b0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (bus.result_valid) state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (bus.result_valid) begin
            cap_q <= bus.result_count;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          meas_valid_q <= 1'b1;
          meas_count_q <= cap_q;
          meas_range_q <= range_q;
          over_q       <= (range_q == 2'd2) && is_hi;
          under_q      <= (range_q == 2'd0) && is_lo;
          hold_q       <= hold_nxt;
          hold_dn_q    <= dn_nxt;
          if (target != range_q) begin
            range_q       <= target;
            period_q      <= period_of(target);
            period_load_q <= 1'b1;
            state         <= S_LOAD;
          end else begin
            state <= S_MEASURE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.period      = period_q;
  assign bus.period_load = period_load_q;
  assign bus.range       = range_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.meas_count  = meas_count_q;
  assign bus.meas_range  = meas_range_q;
  assign bus.over_range  = over_q;
  assign bus.under_range = under_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_autorange_controller.sv
// Bench for autorange_controller: result-level reference model compared every cycle,
// directed scenarios pinned with literal values, then randomized results.
module tb_autorange_controller;
  localparam int BITS   = 12;
  localparam int HI     = 95;
  localparam int LO     = 9;
  localparam int HOLD_N = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  autorange_controller_if #(.BITS(BITS)) bus();

  autorange_controller #(
    .BITS(BITS), .PERIOD0(1199), .PERIOD1(119), .PERIOD2(11),
    .HI_THRESH(HI), .LO_THRESH(LO), .HOLD_N(HOLD_N)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic int pf(input int r);
    return (r == 0) ? 1199 : (r == 1) ? 119 : 11;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks results, not states. Expected visible outputs after each edge.
  int edges = 0;
  bit pend = 0;
  int due = 0;
  int pcount = 0;
  bit discard = 0;
  int streak = 0;
  int e_range = 0, e_period = 1199, e_mv = 0, e_pl = 0;
  int e_mc = 0, e_mr = 0, e_over = 0, e_under = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edges = 0; pend = 0; discard = 0; streak = 0;
      e_range = 0; e_period = 1199; e_mv = 0; e_pl = 0;
      e_mc = 0; e_mr = 0; e_over = 0; e_under = 0;
    end else begin
      int c, r, t;
      edges++;
      e_mv = 0;
      e_pl = 0;
      if (edges == 1) begin
        e_pl = 1; e_period = pf(e_range); discard = 1; streak = 0;
      end
      if (pend && edges == due) begin
        pend = 0;
        c = pcount; r = e_range; t = r;
        e_mv = 1; e_mc = c; e_mr = r;
        e_over  = (r == 2 && c >= HI) ? 1 : 0;
        e_under = (r == 0 && c <= LO) ? 1 : 0;
        if (bus.manual_en) begin
          t = (int'(bus.manual_range) > 2) ? 2 : int'(bus.manual_range);
          streak = 0;
        end else if (c >= HI && r < 2) begin
          streak = (streak > 0) ? streak + 1 : 1;
          if (streak >= HOLD_N) t = r + 1;
        end else if (c <= LO && r > 0) begin
          streak = (streak < 0) ? streak - 1 : -1;
          if (-streak >= HOLD_N) t = r - 1;
        end else begin
          streak = 0;
        end
        if (t != r) begin
          e_range = t; e_period = pf(t); e_pl = 1; discard = 1; streak = 0;
        end
      end
      if (bus.result_valid && edges >= 2) begin
        if (discard) discard = 0;
        else begin
          pend = 1; due = edges + 1; pcount = int'(bus.result_count);
        end
      end
    end
  end

  int mv_count = 0;
  int pl_count = 0;
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) mv_count++;
    if (bus.period_load === 1'b1) pl_count++;
    chk("range", int'(bus.range), e_range);
    chk("period", int'(bus.period), e_period);
    chk("period_load", int'(bus.period_load), e_pl);
    chk("meas_valid", int'(bus.meas_valid), e_mv);
    chk("meas_count", int'(bus.meas_count), e_mc);
    chk("meas_range", int'(bus.meas_range), e_mr);
    chk("over_range", int'(bus.over_range), e_over);
    chk("under_range", int'(bus.under_range), e_under);
  end

  task automatic send(input int c, input int gap);
    repeat (gap) @(negedge clk);
    bus.result_valid = 1'b1;
    bus.result_count = 7'(c);
    @(negedge clk);
    bus.result_valid = 1'b0;
    bus.result_count = 7'($urandom);
  endtask

  task automatic send_settle(input int c);
    send(c, 14);
    repeat (3) @(negedge clk);
  endtask

  int mv0, pl0;

  initial begin
    bus.result_valid = 1'b0;
    bus.result_count = 7'd0;
    bus.manual_en    = 1'b0;
    bus.manual_range = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", int'(bus.period), 1199);
    chk("rst_state", int'(bus.dbg_state), 0);
    chk("rst_load", int'(bus.period_load), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("init_load_strobe", int'(bus.period_load), 1);
    chk("init_state_load", int'(bus.dbg_state), 1);
    chk("init_period", int'(bus.period), 1199);

    mv0 = mv_count;
    send_settle(40);
    chk("first_discarded", mv_count - mv0, 0);

    mv0 = mv_count; pl0 = pl_count;
    send_settle(97);
    chk("hold1_range", int'(bus.range), 0);
    send_settle(97);
    chk("step_up_range", int'(bus.range), 1);
    chk("step_up_period", int'(bus.period), 119);
    chk("step_up_mv", mv_count - mv0, 2);
    chk("step_up_pl", pl_count - pl0, 1);

    mv0 = mv_count;
    send_settle(20);
    chk("after_change_discard", mv_count - mv0, 0);
    send_settle(5);
    send_settle(50);
    send_settle(5);
    chk("hyst_range", int'(bus.range), 1);
    chk("hyst_count", int'(bus.meas_count), 5);
    chk("hyst_mrange", int'(bus.meas_range), 1);
    chk("hyst_mv", mv_count - mv0, 3);

    send_settle(97); send_settle(97); send_settle(60);
    chk("r2_range", int'(bus.range), 2);
    send_settle(127);
    chk("over_flag", int'(bus.over_range), 1);
    chk("over_range_stays", int'(bus.range), 2);

    send_settle(3); send_settle(3); send_settle(50);
    send_settle(3); send_settle(3); send_settle(50);
    chk("r0_range", int'(bus.range), 0);
    send_settle(0);
    chk("under_flag", int'(bus.under_range), 1);
    chk("under_range_stays", int'(bus.range), 0);

    bus.manual_en = 1'b1;
    bus.manual_range = 2'd3;
    pl0 = pl_count;
    send_settle(50);
    chk("manual_range", int'(bus.range), 2);
    chk("manual_period", int'(bus.period), 11);
    chk("manual_pl", pl_count - pl0, 1);
    bus.manual_en = 1'b0;

    // Now in SETTLE: present a result, then pull reset mid-cycle.
    repeat (5) @(negedge clk);
    bus.result_valid = 1'b1;
    bus.result_count = 7'd100;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_range", int'(bus.range), 0);
    chk("abort_period", int'(bus.period), 1199);
    chk("abort_state", int'(bus.dbg_state), 0);
    chk("abort_mv", int'(bus.meas_valid), 0);
    @(negedge clk);
    bus.result_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reinit_load_strobe", int'(bus.period_load), 1);
    chk("reinit_period", int'(bus.period), 1199);

    for (int i = 0; i < 300; i++) begin
      int band, c;
      if ($urandom_range(0, 9) == 0) begin
        bus.manual_en = 1'($urandom_range(0, 1));
        bus.manual_range = 2'($urandom_range(0, 3));
      end
      if (i == 120 || i == 230) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
      band = $urandom_range(0, 2);
      c = (band == 0) ? $urandom_range(HI, 127) :
          (band == 1) ? $urandom_range(0, LO) : $urandom_range(LO + 1, HI - 1);
      send(c, $urandom_range(12, 25));
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
